// File: rtl/ask4_slicer.sv
// 4-level ASK symbol slicer: picks one sample per symbol, estimates the decision
// threshold from the mean magnitude, slices to Gray codes and tracks decision error.
module ask4_slicer #(
    parameter int SPS    = 4,
    parameter int LOG2_N = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [17:0]        x_in,
    input  logic [$clog2(SPS)-1:0]    phase,
    output logic [1:0]                sym_out,
    output logic                      sym_valid,
    output logic [17:0]               ref_level,
    output logic [25:0]               err_sum,
    output logic                      win_done,
    output logic                      locked
);

    localparam int PW    = $clog2(SPS);
    localparam int ACC_W = 17 + LOG2_N;

    typedef enum logic {
        ACQ   = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t state, state_next;

    logic [PW-1:0]     cnt;
    logic [LOG2_N-1:0] sym_cnt;
    logic [ACC_W-1:0]  abs_acc;
    logic [25:0]       err_acc;

    logic              strobe;
    logic              win_end;
    logic [17:0]       neg_x;
    logic [16:0]       abs_s;
    logic [ACC_W-1:0]  abs_sum;
    logic [16:0]       ref_new;
    logic [16:0]       ref_cur;
    logic [16:0]       half;
    logic [17:0]       three_half;
    logic signed [18:0] s19;
    logic signed [18:0] ref19;
    logic [1:0]        dec;
    logic signed [19:0] ideal;
    logic signed [19:0] diff;
    logic [19:0]       err_abs;
    logic [26:0]       err_ext;
    logic [25:0]       err_sat;

    // The strobe follows phase combinationally, so a phase change lands on the
    // next compare even if that gives 0 or 2 strobes in one symbol period.
    assign strobe  = (cnt == phase);
    assign win_end = strobe && (&sym_cnt);

    // |s| saturates the single unrepresentable case -131072 to 131071.
    assign neg_x   = -x_in;
    assign abs_s   = x_in[17] ? (neg_x[17] ? 17'h1FFFF : neg_x[16:0]) : x_in[16:0];
    assign abs_sum = abs_acc + {{(ACC_W-17){1'b0}}, abs_s};
    assign ref_new = abs_sum[ACC_W-1:LOG2_N];

    assign ref_cur    = ref_level[16:0];
    assign half       = {1'b0, ref_cur[16:1]};
    assign three_half = {1'b0, ref_cur} + {1'b0, half};

    assign s19   = {x_in[17], x_in};
    assign ref19 = {2'b00, ref_cur};

    always_comb begin
        dec = 2'b00;
        if (s19 >= ref19)
            dec = 2'b10;
        else if (s19 >= 19'sd0)
            dec = 2'b11;
        else if (s19 >= -ref19)
            dec = 2'b01;
        else
            dec = 2'b00;
    end

    always_comb begin
        ideal = -{2'b00, three_half};
        case (dec)
            2'b10:   ideal = {2'b00, three_half};
            2'b11:   ideal = {3'b000, half};
            2'b01:   ideal = -{3'b000, half};
            default: ideal = -{2'b00, three_half};
        endcase
    end

    assign diff    = {x_in[17], x_in[17], x_in} - ideal;
    assign err_abs = diff[19] ? -diff : diff;
    assign err_ext = {1'b0, err_acc} + {7'b0, err_abs};
    assign err_sat = err_ext[26] ? {26{1'b1}} : err_ext[25:0];

    always_ff @(posedge clk) begin
        if (reset)
            state <= ACQ;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (win_end) begin
            case (state)
                ACQ:     if (ref_new != 17'd0) state_next = TRACK;
                TRACK:   if (ref_new == 17'd0) state_next = ACQ;
                default: state_next = ACQ;
            endcase
        end
    end

    assign locked = (state == TRACK);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            sym_cnt   <= '0;
            abs_acc   <= '0;
            err_acc   <= '0;
            sym_out   <= 2'b00;
            sym_valid <= 1'b0;
            ref_level <= '0;
            err_sum   <= '0;
            win_done  <= 1'b0;
        end else begin
            cnt       <= cnt + PW'(1);
            sym_valid <= 1'b0;
            win_done  <= 1'b0;
            if (strobe) begin
                sym_cnt <= sym_cnt + LOG2_N'(1);
                // Decisions use the threshold from the previous window, including
                // the window's final symbol.
                if (state == TRACK) begin
                    sym_out   <= dec;
                    sym_valid <= 1'b1;
                end
                if (win_end) begin
                    abs_acc   <= '0;
                    err_acc   <= '0;
                    ref_level <= {1'b0, ref_new};
                    err_sum   <= (state == TRACK) ? err_sat : 26'd0;
                    win_done  <= 1'b1;
                end else begin
                    abs_acc <= abs_sum;
                    if (state == TRACK)
                        err_acc <= err_sat;
                end
            end
        end
    end

endmodule
